// File: rtl/io_multiplier.sv
// Memory-mapped iterative unsigned multiplier for the FemtoRV IO bus.
// A write to B starts a shift-add multiply of A*B; busy is high until the product lands in RESULT/RESULT_HI.
module io_multiplier #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel_a,
  input  logic             sel_b,
  input  logic             sel_result,
  input  logic             sel_result_hi,
  input  logic             wstrb,
  input  logic             rstrb,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             busy
);

  localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW    = $clog2(STEPS) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   a, b, res_lo, res_hi;
  logic [WIDTH-1:0]   mplr, mplr_step;
  logic [2*WIDTH-1:0] mcand, mcand_step, acc, acc_step;
  logic [CW-1:0]      cnt;
  logic               start, done;
  logic               unused_rstrb;

  assign unused_rstrb = rstrb;
  assign start        = wstrb & sel_b;
  assign done         = (state == RUN) && (cnt == CW'(1));
  assign busy         = (state == RUN);

  // Retire BITS_PER_CYCLE multiplier bits per clock, LSB first.
  always_comb begin
    mcand_step = mcand;
    mplr_step  = mplr;
    acc_step   = acc;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplr_step[0]) acc_step = acc_step + mcand_step;
      mcand_step = mcand_step << 1;
      mplr_step  = mplr_step >> 1;
    end
  end

  always_comb begin
    state_next = state;
    if (start)     state_next = RUN;
    else if (done) state_next = IDLE;
  end

  always_comb begin
    rdata = '0;
    if (sel_a)              rdata = a;
    else if (sel_b)         rdata = b;
    else if (sel_result)    rdata = res_lo;
    else if (sel_result_hi) rdata = res_hi;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      res_lo <= '0;
      res_hi <= '0;
      mcand  <= '0;
      mplr   <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      state <= state_next;
      if (wstrb && sel_a) a <= wdata;
      // A B write restarts even mid-run or on the completion edge; the aborted product is dropped.
      if (start) begin
        b     <= wdata;
        mcand <= {{WIDTH{1'b0}}, a};
        mplr  <= wdata;
        acc   <= '0;
        cnt   <= CW'(STEPS);
      end else if (state == RUN) begin
        mcand <= mcand_step;
        mplr  <= mplr_step;
        acc   <= acc_step;
        cnt   <= cnt - CW'(1);
        if (done) {res_hi, res_lo} <= acc_step;
      end
    end
  end

endmodule

// File: tb/tb_io_multiplier.sv
// Self-checking bench for io_multiplier: one-bit and four-bit-per-cycle instances share the bus,
// expected products and busy lengths come from plain 64-bit arithmetic.
module tb_io_multiplier;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  sel_vec = '0;
  logic        wstrb = 1'b0;
  logic        rstrb = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata, rdata4;
  logic        busy, busy4;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  localparam logic [3:0] S_A = 4'b0001, S_B = 4'b0010, S_LO = 4'b0100, S_HI = 4'b1000;

  always #5 clk = ~clk;

  io_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(reset),
    .sel_a(sel_vec[0]), .sel_b(sel_vec[1]), .sel_result(sel_vec[2]), .sel_result_hi(sel_vec[3]),
    .wstrb(wstrb), .rstrb(rstrb), .wdata(wdata), .rdata(rdata), .busy(busy)
  );

  io_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset),
    .sel_a(sel_vec[0]), .sel_b(sel_vec[1]), .sel_result(sel_vec[2]), .sel_result_hi(sel_vec[3]),
    .wstrb(wstrb), .rstrb(rstrb), .wdata(wdata), .rdata(rdata4), .busy(busy4)
  );

  task automatic wr(input logic [3:0] sel, input logic [31:0] d);
    @(negedge clk);
    sel_vec = sel; wstrb = 1'b1; wdata = d;
    @(posedge clk); #1;
    sel_vec = '0; wstrb = 1'b0;
  endtask

  task automatic rd(input logic [3:0] sel, output logic [31:0] v, output logic [31:0] v4);
    sel_vec = sel; rstrb = 1'b1;
    #1;
    v = rdata; v4 = rdata4;
    sel_vec = '0; rstrb = 1'b0;
  endtask

  task automatic wait_idle(input bit use4, output int unsigned n);
    n = 0;
    while ((use4 ? busy4 : busy) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_product(input string name, input logic [31:0] a, input logic [31:0] b,
                               input bit use4);
    logic [63:0] p;
    logic [31:0] lo, hi, l4, h4;
    p = 64'(a) * 64'(b);
    rd(S_LO, lo, l4);
    rd(S_HI, hi, h4);
    if (use4) begin lo = l4; hi = h4; end
    n_cmp++;
    if (lo !== p[31:0]) begin
      n_fail++; $display("FAIL %s lo: got %h want %h", name, lo, p[31:0]);
    end
    n_cmp++;
    if (hi !== p[63:32]) begin
      n_fail++; $display("FAIL %s hi: got %h want %h", name, hi, p[63:32]);
    end
  endtask

  task automatic test_reset;
    logic [31:0] v, v4;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || busy4 !== 1'b0) begin
      n_fail++; $display("FAIL reset busy: got %b/%b want 0", busy, busy4);
    end
    for (int i = 0; i < 5; i++) begin
      rd(i == 0 ? 4'b0000 : 4'(1 << (i - 1)), v, v4);
      n_cmp++;
      if (v !== 32'h0 || v4 !== 32'h0) begin
        n_fail++; $display("FAIL reset rdata sel%0d: got %h/%h want 0", i, v, v4);
      end
    end
  endtask

  task automatic test_multiply;
    logic [31:0] a, b, v, v4;
    int unsigned n;
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: begin a = 32'd3; b = 32'd5; end
        1: begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
        2: begin a = 32'h0; b = $urandom; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      wr(S_A, a);
      wr(S_B, b);
      wait_idle(1'b0, n);
      n_cmp++;
      if (n !== 32) begin
        n_fail++; $display("FAIL mul%0d busy cycles: got %0d want 32", k, n);
      end
      check_product($sformatf("mul%0d", k), a, b, 1'b0);
      rd(S_A, v, v4);
      n_cmp++;
      if (v !== a) begin n_fail++; $display("FAIL mul%0d A readback: got %h want %h", k, v, a); end
      rd(S_B, v, v4);
      n_cmp++;
      if (v !== b) begin n_fail++; $display("FAIL mul%0d B readback: got %h want %h", k, v, b); end
    end
  endtask

  task automatic test_restart;
    int unsigned n, k;
    logic [31:0] a, b0, b1;
    wr(S_A, 32'd2);
    wr(S_B, 32'd7);
    repeat (9) @(posedge clk);
    wr(S_B, 32'd9);
    repeat (4) @(posedge clk);
    wr(S_A, 32'd100);
    wait_idle(1'b0, n);
    n_cmp++;
    if (10 + 5 + n !== 42) begin
      n_fail++; $display("FAIL restart busy total: got %0d want 42", 10 + 5 + n);
    end
    check_product("restart", 32'd2, 32'd9, 1'b0);
    wr(S_B, 32'd1);
    wait_idle(1'b0, n);
    check_product("newA", 32'd100, 32'd1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      a = $urandom; b0 = $urandom; b1 = $urandom;
      k = $urandom_range(31, 1);
      wr(S_A, a);
      wr(S_B, b0);
      repeat (k - 1) @(posedge clk);
      wr(S_B, b1);
      wait_idle(1'b0, n);
      n_cmp++;
      if (k + n !== 32 + k) begin
        n_fail++; $display("FAIL rnd restart%0d busy: got %0d want %0d", r, k + n, 32 + k);
      end
      check_product($sformatf("rnd restart%0d", r), a, b1, 1'b0);
    end
  endtask

  task automatic test_decode;
    logic [31:0] v, v4, a, b;
    int unsigned n;
    a = $urandom; b = $urandom;
    wr(S_A, a);
    wr(S_B, b);
    wait_idle(1'b0, n);
    wr(S_LO, 32'hDEAD_BEEF);
    wr(S_HI, 32'hCAFE_F00D);
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL result write busy: got %b want 0", busy); end
    check_product("result write ignored", a, b, 1'b0);
    rd(S_A | S_B | S_LO, v, v4);
    n_cmp++;
    if (v !== a) begin n_fail++; $display("FAIL prio A: got %h want %h", v, a); end
    rd(S_B | S_HI, v, v4);
    n_cmp++;
    if (v !== b) begin n_fail++; $display("FAIL prio B: got %h want %h", v, b); end
    rd(S_LO | S_HI, v, v4);
    n_cmp++;
    if (v !== 32'(64'(a) * 64'(b))) begin
      n_fail++; $display("FAIL prio LO: got %h want %h", v, 32'(64'(a) * 64'(b)));
    end
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] v, v4;
    wr(S_A, 32'hFFFF);
    wr(S_B, 32'hFFFF);
    repeat (15) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid reset busy: got %b want 0", busy); end
    @(negedge clk); reset = 1'b0;
    check_product("mid reset result", 32'h0, 32'h0, 1'b0);
    rd(S_A, v, v4);
    n_cmp++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL mid reset A: got %h want 0", v); end
  endtask

  task automatic test_bpc4;
    logic [31:0] a, b;
    int unsigned n;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin a = 32'h0001_0000; b = 32'h0001_0000; end
      else begin a = $urandom; b = $urandom; end
      wr(S_A, a);
      wr(S_B, b);
      wait_idle(1'b1, n);
      n_cmp++;
      if (n !== 8) begin n_fail++; $display("FAIL bpc4 %0d busy cycles: got %0d want 8", k, n); end
      check_product($sformatf("bpc4 %0d", k), a, b, 1'b1);
      wait_idle(1'b0, n);
    end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_restart();
    test_decode();
    test_reset_mid_run();
    test_bpc4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
